sap_exec_core: RTL and testbench

- Execution core of the SAP-1 style 8-bit computer.
- Combines three functions: a six-state ring-counter controller producing the 12-bit control word, the accumulator (A) register, and the 8-bit adder/subtractor.
- Connects to the shared W bus through separate data/enable pairs; no internal tri-states. The top-level bus mux resolves these.
- The program counter, memory, IR, B and output registers live outside this block.

---
 rtl/sap_exec_core.sv | 99 +++++++++
 tb/tb_sap_exec_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sap_exec_core.sv
// sap_exec_core: SAP-1 ring-counter controller, accumulator and adder/subtractor
module sap_exec_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instruction,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] b_value,
  output logic [11:0]      control_word,
  output logic [5:0]       t_state,
  output logic             halt,
  output logic [WIDTH-1:0] acc_value,
  output logic [WIDTH-1:0] acc_bus_data,
  output logic             acc_bus_en,
  output logic [WIDTH-1:0] alu_bus_data,
  output logic             alu_bus_en,
  output logic             carry
);
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;
  localparam logic [11:0] NOP = 12'h3E3;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  state_t           r_state;
  state_t           w_next;
  logic             r_halt;
  logic             w_set_halt;
  logic [WIDTH-1:0] r_acc;
  logic [11:0]      w_cw;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  // ring state and sticky halt flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= T1;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_halt  <= r_halt | w_set_halt;
    end
  end
  // advance the ring unless halted or halting on this edge (which freezes at T4)
  always_comb begin
    w_set_halt = !r_halt && r_state == T4 && instruction == OP_HLT;
    w_next     = r_state;
    if (!r_halt && !w_set_halt)
      case (r_state)
        T1:      w_next = T2;
        T2:      w_next = T3;
        T3:      w_next = T4;
        T4:      w_next = T5;
        T5:      w_next = T6;
        default: w_next = T1;
      endcase
  end
  // control word: fetch in T1-T3, opcode-specific execute in T4-T6, NOP once halted
  always_comb begin
    w_cw = NOP;
    if (!r_halt)
      case (r_state)
        T1:      w_cw = 12'h5E3;
        T2:      w_cw = 12'hBE3;
        T3:      w_cw = 12'h263;
        T4:      w_cw = (instruction == OP_LDA || instruction == OP_ADD || instruction == OP_SUB) ? 12'h1A3 :
                        (instruction == OP_OUT) ? 12'h3F2 : NOP;
        T5:      w_cw = (instruction == OP_LDA) ? 12'h2C3 :
                        (instruction == OP_ADD || instruction == OP_SUB) ? 12'h2E1 : NOP;
        T6:      w_cw = (instruction == OP_ADD) ? 12'h3C7 :
                        (instruction == OP_SUB) ? 12'h3CF : NOP;
        default: w_cw = NOP;
      endcase
  end
  // accumulator loads from the bus whenever La_n is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_acc <= '0;
    else if (!w_cw[5]) r_acc <= bus_in;
  end
  assign w_b          = w_cw[3] ? ~b_value : b_value;
  assign w_sum        = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cw[3]};
  assign control_word = w_cw;
  assign t_state      = r_state;
  assign halt         = r_halt;
  assign acc_value    = r_acc;
  assign acc_bus_data = r_acc;
  assign acc_bus_en   = w_cw[4];
  assign alu_bus_data = w_sum[WIDTH-1:0];
  assign alu_bus_en   = w_cw[2];
  assign carry        = w_sum[WIDTH];
endmodule

// File: tb/tb_sap_exec_core.sv
// tb_sap_exec_core: randomized and directed checks of sap_exec_core against a behavioural model
module tb_sap_exec_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  instruction = '0;
  logic [7:0]  bus_in = '0;
  logic [7:0]  b_value = '0;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halt;
  logic [7:0]  acc_value, acc_bus_data, alu_bus_data;
  logic        acc_bus_en, alu_bus_en, carry;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int m_step;
  bit m_halt;
  int m_acc;

  sap_exec_core #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .bus_in(bus_in),
    .b_value(b_value), .control_word(control_word), .t_state(t_state), .halt(halt),
    .acc_value(acc_value), .acc_bus_data(acc_bus_data), .acc_bus_en(acc_bus_en),
    .alu_bus_data(alu_bus_data), .alu_bus_en(alu_bus_en), .carry(carry)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_cw();
    int lda[3] = '{'h1A3, 'h2C3, 'h3E3};
    int add[3] = '{'h1A3, 'h2E1, 'h3C7};
    int sub[3] = '{'h1A3, 'h2E1, 'h3CF};
    int out[3] = '{'h3F2, 'h3E3, 'h3E3};
    if (m_halt) return 'h3E3;
    if (m_step == 0) return 'h5E3;
    if (m_step == 1) return 'hBE3;
    if (m_step == 2) return 'h263;
    case (instruction)
      4'h0:    return lda[m_step-3];
      4'h1:    return add[m_step-3];
      4'h2:    return sub[m_step-3];
      4'hE:    return out[m_step-3];
      default: return 'h3E3;
    endcase
  endfunction

  function automatic bit is_sub();
    return !m_halt && m_step == 5 && instruction == 4'h2;
  endfunction

  function automatic int exp_alu();
    return is_sub() ? (m_acc - int'(b_value) + 256) % 256 : (m_acc + int'(b_value)) % 256;
  endfunction

  function automatic int exp_carry();
    return is_sub() ? int'(m_acc >= int'(b_value)) : int'(m_acc + int'(b_value) > 255);
  endfunction

  task automatic model_reset();
    m_step = 0;
    m_halt = 0;
    m_acc  = 0;
  endtask

  task automatic model_edge();
    if (!reset || m_halt) return;
    if ((m_step == 4 && instruction == 4'h0) || (m_step == 5 && (instruction == 4'h1 || instruction == 4'h2)))
      m_acc = int'(bus_in);
    if (m_step == 3 && instruction == 4'hF) m_halt = 1;
    else m_step = (m_step + 1) % 6;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      #1;
    end
  endtask

  task automatic assert_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    #3;
    reset = 1'b1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [7:0] bus, input logic [7:0] b);
    instruction = op;
    bus_in = bus;
    b_value = b;
  endtask

  // compare every DUT output with the model on each falling edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("t_state", int'(t_state), 1 << m_step);
      chk("control_word", int'(control_word), exp_cw());
      chk("halt", int'(halt), int'(m_halt));
      chk("acc_value", int'(acc_value), m_acc);
      chk("acc_bus_data", int'(acc_bus_data), m_acc);
      chk("acc_bus_en", int'(acc_bus_en), int'(!m_halt && m_step == 3 && instruction == 4'hE));
      chk("alu_bus_en", int'(alu_bus_en), int'(!m_halt && m_step == 5 && (instruction == 4'h1 || instruction == 4'h2)));
      chk("alu_bus_data", int'(alu_bus_data), exp_alu());
      chk("carry", int'(carry), exp_carry());
    end
  end

  initial begin
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1;
    tick(2);
    chk("rst_t_state", int'(t_state), 'h01);
    chk("rst_cw", int'(control_word), 'h5E3);
    chk("rst_acc", int'(acc_value), 0);
    chk("rst_halt", int'(halt), 0);
    reset = 1'b1;
    set_in(4'h0, 8'h0A, 8'h00);
    tick(5);
    chk("lda_acc", int'(acc_value), 'h0A);
    chk("lda_t6_cw", int'(control_word), 'h3E3);
    tick(1);
    chk("ring_back_t1", int'(t_state), 'h01);
    set_in(4'h1, 8'h12, 8'h08);
    tick(5);
    chk("add_alu", int'(alu_bus_data), 'h12);
    chk("add_carry", int'(carry), 0);
    chk("add_t6_cw", int'(control_word), 'h3C7);
    tick(1);
    chk("add_acc", int'(acc_value), 'h12);
    set_in(4'h0, 8'h02, 8'h00);
    tick(6);
    set_in(4'h2, 8'hFE, 8'h04);
    tick(5);
    chk("sub_alu", int'(alu_bus_data), 'hFE);
    chk("sub_carry", int'(carry), 0);
    chk("sub_t6_cw", int'(control_word), 'h3CF);
    tick(1);
    set_in(4'h0, 8'hFF, 8'h00);
    tick(6);
    set_in(4'h1, 8'h00, 8'h01);
    tick(5);
    chk("wrap_alu", int'(alu_bus_data), 'h00);
    chk("wrap_carry", int'(carry), 1);
    tick(1);
    set_in(4'hE, 8'h00, 8'h00);
    tick(3);
    chk("out_t4_cw", int'(control_word), 'h3F2);
    chk("out_acc_en", int'(acc_bus_en), 1);
    tick(3);
    set_in(4'hF, 8'h33, 8'h00);
    tick(4);
    chk("hlt_halt", int'(halt), 1);
    chk("hlt_t_state", int'(t_state), 'h08);
    instruction = 4'h0;
    tick(12);
    chk("halted_t_state", int'(t_state), 'h08);
    chk("halted_cw", int'(control_word), 'h3E3);
    assert_reset();
    chk("arst_halt", int'(halt), 0);
    chk("arst_cw", int'(control_word), 'h5E3);
    release_reset();
    set_in(4'h0, 8'h55, 8'h00);
    tick(6);
    set_in(4'h1, 8'h58, 8'h03);
    tick(4);
    assert_reset();
    chk("arst_mid_t_state", int'(t_state), 'h01);
    chk("arst_mid_acc", int'(acc_value), 0);
    chk("arst_mid_cw", int'(control_word), 'h5E3);
    release_reset();
    tick(1);
    chk("resume_t2", int'(t_state), 'h02);
    for (int i = 0; i < 3000; i++) begin
      if (m_step == 0 && !m_halt) begin
        case ($urandom_range(0, 9))
          0, 1:    instruction = 4'h0;
          2, 3:    instruction = 4'h1;
          4, 5:    instruction = 4'h2;
          6:       instruction = 4'hE;
          7:       instruction = 4'hF;
          default: instruction = 4'($urandom);
        endcase
      end
      bus_in = 8'($urandom);
      b_value = 8'($urandom);
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        assert_reset();
        release_reset();
      end
      tick(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
